// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between requesters A and B.
// After reset every RAM word is cleared, then a round-robin arbiter grants at
// most one access per clock. Reads are tagged with their issuing port and the
// returned RAM data is steered back to that port RD_LAT+1 clocks after grant.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic {StInit, StRun} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_init_cnt, w_init_cnt_nxt;
    logic              r_rr, w_rr_nxt;       // 0: A wins a tie, 1: B wins a tie
    logic [ADDR_W-1:0] r_addr_hold;          // last driven RAM address, held when idle
    logic [DATA_W-1:0] r_data_hold;
    logic              w_sel_a, w_sel_b;
    logic              w_wren;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_push, w_push_port;
    logic [RD_LAT-1:0] r_tag_v, r_tag_p;     // tag pipe: valid and port (1 = B)
    logic              r_a_rvalid, r_b_rvalid;
    logic [DATA_W-1:0] r_a_rdata, r_b_rdata;

    // Next state, arbitration and RAM-side drive.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_rr_nxt       = r_rr;
        w_sel_a        = 1'b0;
        w_sel_b        = 1'b0;
        w_wren         = 1'b0;
        w_addr         = r_addr_hold;
        w_data         = r_data_hold;
        unique case (r_state)
            StInit: begin
                w_wren         = 1'b1;
                w_addr         = r_init_cnt;
                w_data         = '0;
                w_init_cnt_nxt = r_init_cnt + ADDR_W'(1);
                if (r_init_cnt == {ADDR_W{1'b1}}) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                w_sel_a = a_req & (~b_req | ~r_rr);
                w_sel_b = b_req & ~w_sel_a;
                if (w_sel_a) begin
                    w_wren   = a_we;
                    w_addr   = a_addr;
                    w_data   = a_wdata;
                    w_rr_nxt = 1'b1;
                end else if (w_sel_b) begin
                    w_wren   = b_we;
                    w_addr   = b_addr;
                    w_data   = b_wdata;
                    w_rr_nxt = 1'b0;
                end
            end
            default: w_state_nxt = StInit;
        endcase
    end

    assign w_push      = (w_sel_a & ~a_we) | (w_sel_b & ~b_we);
    assign w_push_port = w_sel_b;

    assign a_gnt       = w_sel_a;
    assign b_gnt       = w_sel_b;
    assign busy        = (r_state == StInit);
    assign ram_wren    = w_wren;
    assign ram_address = w_addr;
    assign ram_data    = w_data;
    assign a_rvalid    = r_a_rvalid;
    assign b_rvalid    = r_b_rvalid;
    assign a_rdata     = r_a_rdata;
    assign b_rdata     = r_b_rdata;

    // Control state: FSM, clear counter, round-robin pointer, idle hold values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= StInit;
            r_init_cnt  <= '0;
            r_rr        <= 1'b0;
            r_addr_hold <= '0;
            r_data_hold <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_cnt  <= w_init_cnt_nxt;
            r_rr        <= w_rr_nxt;
            r_addr_hold <= w_addr;
            r_data_hold <= w_data;
        end
    end

    // Read tag pipe; the tag leaving the pipe lines up with valid ram_q.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tag_v <= '0;
            r_tag_p <= '0;
        end else begin
            r_tag_v[0] <= w_push;
            r_tag_p[0] <= w_push_port;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_p[i] <= r_tag_p[i-1];
            end
        end
    end

    // Capture returning read data into the issuing port and pulse its rvalid.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            if (r_tag_v[RD_LAT-1]) begin
                if (r_tag_p[RD_LAT-1]) begin
                    r_b_rdata  <= ram_q;
                    r_b_rvalid <= 1'b1;
                end else begin
                    r_a_rdata  <= ram_q;
                    r_a_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (RD_LAT=1 and RD_LAT=2) share stimulus,
// each with its own RAM model; a transaction-level model checks every cycle.
module tb_ram_arbiter;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [4:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0;

    logic       a_gnt1, a_rvalid1, b_gnt1, b_rvalid1, busy1, ram_wren1;
    logic [7:0] a_rdata1, b_rdata1, ram_data1, q1;
    logic [4:0] ram_address1;
    logic       a_gnt2, a_rvalid2, b_gnt2, b_rvalid2, busy2, ram_wren2;
    logic [7:0] a_rdata2, b_rdata2, ram_data2, q2, q2a;
    logic [4:0] ram_address2;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clock = ~clock;

    ram_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) u_dut1 (
        .clock(clock), .resetn(resetn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
        .busy(busy1), .ram_address(ram_address1), .ram_data(ram_data1),
        .ram_wren(ram_wren1), .ram_q(q1)
    );

    ram_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2)) u_dut2 (
        .clock(clock), .resetn(resetn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt2), .a_rvalid(a_rvalid2), .a_rdata(a_rdata2),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt2), .b_rvalid(b_rvalid2), .b_rdata(b_rdata2),
        .busy(busy2), .ram_address(ram_address2), .ram_data(ram_data2),
        .ram_wren(ram_wren2), .ram_q(q2)
    );

    // RAM models: synchronous single-port, 1 and 2 clocks of read latency.
    logic [7:0] mem1 [32];
    logic [7:0] mem2 [32];
    always @(posedge clock) begin
        if (ram_wren1) mem1[ram_address1] <= ram_data1;
        q1 <= mem1[ram_address1];
    end
    always @(posedge clock) begin
        if (ram_wren2) mem2[ram_address2] <= ram_data2;
        q2a <= mem2[ram_address2];
        q2  <= q2a;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk2(input string nm, input logic [31:0] act1, input logic [31:0] act2,
                        input logic [31:0] exp);
        chk({nm, "_lat1"}, act1, exp);
        chk({nm, "_lat2"}, act2, exp);
    endtask

    // Behavioural model: memory image, tie-break preference, pending read returns.
    typedef struct {
        int       due;
        bit       port;  // 1 = B
        bit [7:0] data;
    } rd_t;

    rd_t      pend1[$];
    rd_t      pend2[$];
    bit [7:0] m_mem [32];
    int       m_cnt = 0;
    bit       m_rr = 1'b0;  // 1 when B is favoured on a tie
    bit [4:0] m_last_addr = '0;
    bit [7:0] m_last_data = '0;
    bit [7:0] e1_ard = '0, e1_brd = '0, e2_ard = '0, e2_brd = '0;

    always @(negedge clock) begin
        bit       e1_av, e1_bv, e2_av, e2_bv;
        int       win;
        bit       ewe;
        bit [4:0] eaddr;
        bit [7:0] edata;
        rd_t      r;
        cyc++;
        if (!resetn) begin
            m_cnt = 0;
            m_rr  = 1'b0;
            pend1.delete();
            pend2.delete();
            e1_ard = '0; e1_brd = '0; e2_ard = '0; e2_brd = '0;
            chk2("rst_busy", busy1, busy2, 1);
            chk2("rst_a_gnt", a_gnt1, a_gnt2, 0);
            chk2("rst_b_gnt", b_gnt1, b_gnt2, 0);
            chk2("rst_a_rvalid", a_rvalid1, a_rvalid2, 0);
            chk2("rst_b_rvalid", b_rvalid1, b_rvalid2, 0);
            chk2("rst_a_rdata", a_rdata1, a_rdata2, 0);
            chk2("rst_b_rdata", b_rdata1, b_rdata2, 0);
        end else begin
            e1_av = 0; e1_bv = 0; e2_av = 0; e2_bv = 0;
            if (pend1.size() > 0 && pend1[0].due == cyc) begin
                r = pend1.pop_front();
                if (r.port) begin e1_bv = 1; e1_brd = r.data; end
                else begin e1_av = 1; e1_ard = r.data; end
            end
            if (pend2.size() > 0 && pend2[0].due == cyc) begin
                r = pend2.pop_front();
                if (r.port) begin e2_bv = 1; e2_brd = r.data; end
                else begin e2_av = 1; e2_ard = r.data; end
            end
            chk("a_rvalid_lat1", a_rvalid1, e1_av);
            chk("b_rvalid_lat1", b_rvalid1, e1_bv);
            chk("a_rvalid_lat2", a_rvalid2, e2_av);
            chk("b_rvalid_lat2", b_rvalid2, e2_bv);
            chk("a_rdata_lat1", a_rdata1, e1_ard);
            chk("b_rdata_lat1", b_rdata1, e1_brd);
            chk("a_rdata_lat2", a_rdata2, e2_ard);
            chk("b_rdata_lat2", b_rdata2, e2_brd);
            if (m_cnt < 32) begin
                chk2("init_busy", busy1, busy2, 1);
                chk2("init_wren", ram_wren1, ram_wren2, 1);
                chk2("init_addr", ram_address1, ram_address2, m_cnt);
                chk2("init_data", ram_data1, ram_data2, 0);
                chk2("init_a_gnt", a_gnt1, a_gnt2, 0);
                chk2("init_b_gnt", b_gnt1, b_gnt2, 0);
                m_mem[m_cnt] = 8'h00;
                m_last_addr  = 5'(m_cnt);
                m_last_data  = 8'h00;
                m_cnt++;
            end else begin
                win = 0;
                if (a_req && (!b_req || !m_rr)) win = 1;
                else if (b_req) win = 2;
                ewe = 0; eaddr = m_last_addr; edata = m_last_data;
                if (win == 1) begin ewe = a_we; eaddr = a_addr; edata = a_wdata; end
                if (win == 2) begin ewe = b_we; eaddr = b_addr; edata = b_wdata; end
                chk2("run_busy", busy1, busy2, 0);
                chk2("a_gnt", a_gnt1, a_gnt2, win == 1);
                chk2("b_gnt", b_gnt1, b_gnt2, win == 2);
                chk2("ram_wren", ram_wren1, ram_wren2, ewe);
                chk2("ram_address", ram_address1, ram_address2, eaddr);
                chk2("ram_data", ram_data1, ram_data2, edata);
                if (win != 0) begin
                    if (ewe) m_mem[eaddr] = edata;
                    else begin
                        pend1.push_back('{due: cyc + 2, port: (win == 2), data: m_mem[eaddr]});
                        pend2.push_back('{due: cyc + 3, port: (win == 2), data: m_mem[eaddr]});
                    end
                    m_rr        = (win == 1);
                    m_last_addr = eaddr;
                    m_last_data = edata;
                end
            end
        end
    end

    // Drive one clock of inputs just after the rising edge; return at the falling edge.
    task automatic drive(input logic rst, input logic ar, input logic aw, input logic [4:0] aa,
                         input logic [7:0] ad, input logic br, input logic bw,
                         input logic [4:0] ba, input logic [7:0] bd);
        @(posedge clock);
        #1;
        resetn = rst;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        @(negedge clock);
    endtask

    task automatic idle(input logic rst);
        drive(rst, 0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
    endtask

    initial begin
        int n;
        repeat (3) idle(0);

        // Clear sequence with A holding a read request of address 9.
        drive(1, 1, 0, 5'd9, 8'h00, 0, 0, 5'd0, 8'h00);
        chk("lit_first_busy", busy1, 1);
        chk("lit_first_addr", ram_address1, 0);
        n = 1;
        for (int i = 2; i <= 40; i++) begin
            drive(1, 1, 0, 5'd9, 8'h00, 0, 0, 5'd0, 8'h00);
            n = i;
            if (a_gnt1) break;
        end
        chk("lit_first_gnt_clk", n, 33);

        // Write 5 <- A7, then read 5.
        drive(1, 1, 1, 5'd5, 8'hA7, 0, 0, 5'd0, 8'h00);
        chk("lit_wr_gnt", a_gnt1, 1);
        drive(1, 1, 0, 5'd5, 8'h00, 0, 0, 5'd0, 8'h00);
        chk("lit_rd_gnt", a_gnt1, 1);
        chk("lit_rd9_valid", a_rvalid1, 1);
        chk("lit_rd9_data", a_rdata1, 8'h00);
        idle(1);
        chk("lit_rd9_valid_l2", a_rvalid2, 1);
        idle(1);
        chk("lit_a7_valid", a_rvalid1, 1);
        chk("lit_a7_data", a_rdata1, 8'hA7);
        idle(1);
        chk("lit_a7_valid_l2", a_rvalid2, 1);
        chk("lit_a7_data_l2", a_rdata2, 8'hA7);

        // Both request for 6 clocks; B is favoured first since A won last.
        for (int k = 0; k < 6; k++) begin
            drive(1, 1, 1, 5'd3, 8'h11, 1, 1, 5'd4, 8'h22);
            chk("lit_alternate", {a_gnt1, b_gnt1}, (k % 2 == 0) ? 2'b01 : 2'b10);
        end

        // A reads 3, B reads 4 back to back.
        drive(1, 1, 0, 5'd3, 8'h00, 0, 0, 5'd0, 8'h00);
        drive(1, 0, 0, 5'd0, 8'h00, 1, 0, 5'd4, 8'h00);
        idle(1);
        chk("lit_s4_a_data", a_rdata1, 8'h11);
        idle(1);
        chk("lit_s4_b_valid", b_rvalid1, 1);
        chk("lit_s4_b_data", b_rdata1, 8'h22);
        chk("lit_s4_a_data_l2", a_rdata2, 8'h11);
        idle(1);
        chk("lit_s4_a_hold", a_rdata1, 8'h11);
        chk("lit_s4_b_data_l2", b_rdata2, 8'h22);

        // Read in flight killed by reset, then reset mid-clear at count 17.
        drive(1, 1, 0, 5'd3, 8'h00, 0, 0, 5'd0, 8'h00);
        idle(0);
        repeat (17) idle(1);
        idle(1);
        chk("lit_cnt17", ram_address1, 17);
        idle(0);
        idle(1);
        chk("lit_restart_addr", ram_address1, 0);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (!busy1) break;
            n++;
        end
        chk("lit_clear_len", n, 32);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                repeat ($urandom_range(1, 3)) idle(0);
            end
            drive(1, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 8'($urandom),
                  $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 8'($urandom));
        end
        repeat (5) idle(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
